reflet_bus_fabric: RTL

Parametrised memory-map interconnect between a reflet CPU and up to `regions` slaves, succeeding the hard-wired 16-bit instruction/data/peripheral split. It decodes each CPU access against per-region base/mask pairs and steers byte lanes for 8-bit slaves at any word width. It inserts per-region wait states by stalling the CPU through `cpu_enable`, and flags accesses that hit no region. It sits between `reflet_cpu` and the memories/peripheral block in a controller top.

---
 rtl/reflet_bus_fabric.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/reflet_bus_fabric.sv
// reflet_bus_fabric: address decode, byte-lane steering and wait-state
// insertion between the reflet CPU and a set of base/mask mapped slaves.
module reflet_bus_fabric #(
  parameter int wordsize = 16,
  parameter int regions  = 4,
  parameter logic [regions*wordsize-1:0] region_base   = '0,
  parameter logic [regions*wordsize-1:0] region_mask   = '0,
  parameter logic [regions*4-1:0]        region_wait   = '0,
  parameter logic [regions-1:0]          region_narrow = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [wordsize-1:0]          cpu_addr,
  input  logic [wordsize-1:0]          cpu_wdata,
  input  logic                         cpu_write_en,
  output logic [wordsize-1:0]          cpu_rdata,
  output logic                         cpu_enable,
  output logic [regions-1:0]           slave_sel,
  output logic [wordsize-1:0]          slave_addr,
  output logic [wordsize-1:0]          slave_wdata,
  output logic                         slave_write_en,
  input  logic [regions*wordsize-1:0]  slave_rdata,
  input  logic                         error_clear,
  output logic                         bus_error
);

  localparam int LANES = wordsize / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IW    = (regions > 1) ? $clog2(regions) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [wordsize-1:0] hold_q, hold_d;
  logic                bus_error_q, bus_error_d;

  logic [regions-1:0]  hit;
  logic [IW-1:0]       hit_idx;
  logic                hit_any;
  logic [3:0]          wait_hit;
  logic [IW-1:0]       act_idx;
  logic [wordsize-1:0] rd_sel;
  logic [wordsize-1:0] steered_rd;
  logic [LW-1:0]       lane;
  logic                narrow_act;
  logic                err_set;

  // Raw per-region match of the current address.
  generate
    for (genvar gi = 0; gi < regions; gi++) begin : g_match
      assign hit[gi] = ((cpu_addr & region_mask[gi*wordsize +: wordsize])
                        == region_base[gi*wordsize +: wordsize]);
    end
  endgenerate

  // Lowest-index match wins; isolate the lowest set bit for the select.
  always_comb begin
    hit_idx = '0;
    hit_any = 1'b0;
    for (int i = regions - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = IW'(i);
        hit_any = 1'b1;
      end
    end
  end

  assign slave_sel  = hit & (~hit + regions'(1));
  assign slave_addr = cpu_addr;
  assign wait_hit   = region_wait[hit_idx*4 +: 4];

  // While a wait is in progress the region latched at entry is used.
  assign act_idx    = (state_q == IDLE) ? hit_idx : idx_q;
  assign rd_sel     = slave_rdata[act_idx*wordsize +: wordsize];
  assign narrow_act = region_narrow[act_idx];
  assign lane       = cpu_addr[LW-1:0];

  // Byte-lane steering for 8-bit slaves; wide slaves pass straight through.
  always_comb begin
    steered_rd  = rd_sel;
    slave_wdata = cpu_wdata;
    if (narrow_act) begin
      steered_rd                     = '0;
      steered_rd[int'(lane)*8 +: 8]  = rd_sel[7:0];
      slave_wdata                    = '0;
      slave_wdata[7:0]               = cpu_wdata[int'(lane)*8 +: 8];
    end
  end

  // Next-state, counter, holding register and CPU-facing outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    hold_d         = hold_q;
    cpu_enable     = 1'b1;
    slave_write_en = 1'b0;
    cpu_rdata      = hold_q;
    err_set        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit_any) begin
          cpu_rdata = '0;
          err_set   = 1'b1;
        end else if (wait_hit == 4'd0) begin
          cpu_rdata      = steered_rd;
          slave_write_en = cpu_write_en;
        end else begin
          // This cycle is the first stall cycle; WAIT covers the rest.
          cpu_enable = 1'b0;
          idx_d      = hit_idx;
          cnt_d      = wait_hit - 4'd1;
          if (wait_hit == 4'd1) begin
            hold_d  = steered_rd;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cpu_enable = 1'b0;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          hold_d  = steered_rd;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        slave_write_en = cpu_write_en;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bus_error_d = err_set | (bus_error_q & ~error_clear);
    if (!reset) begin
      cpu_enable     = 1'b1;
      slave_write_en = 1'b0;
      cpu_rdata      = hold_q;
    end
  end

  assign bus_error = bus_error_q;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule
